// File: rtl/hdmi_pll_pkg.sv
// Shared types and 48 MHz default timing for the HDMI PLL lock supervisor.
package hdmi_pll_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 48000;
    localparam int unsigned DEF_STABLE_CYCLES = 4800;
    localparam int unsigned DEF_MAX_RETRIES   = 7;
    localparam int unsigned DEF_TMR_W         = 16;

    localparam int unsigned RETRY_MAX     = 15;
    localparam int unsigned LOCK_LOSS_MAX = 255;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    typedef struct packed {
        logic pll_rst;
        logic run_rst_n;
        logic fail;
    } ctl_t;

    // Moore decode of the control pins for a given state.
    function automatic ctl_t ctl_decode(input state_e st);
        ctl_t c;
        c.pll_rst   = (st == ST_IDLE) || (st == ST_PLL_RST) || (st == ST_FAIL);
        c.run_rst_n = (st == ST_RUN);
        c.fail      = (st == ST_FAIL);
        return c;
    endfunction

endpackage

// File: rtl/hdmi_pll_supervisor_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_pll_supervisor.sv
// PLL lock supervisor: pulses PLL RST, qualifies LOCK, releases the datapath
// reset, and retries on timeout or lock loss until a sticky FAIL.
module hdmi_pll_supervisor
    import hdmi_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned TMR_W         = DEF_TMR_W
) (
    input  logic               inclk0,
    input  logic               resetn,
    input  logic               enable,
    input  logic               locked_async,
    output logic               pll_rst,
    output logic               run_rst_n,
    output logic [STATE_W-1:0] state,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt,
    output logic               fail
);

    localparam longint unsigned TMR_MAX = (64'd1 << TMR_W) - 64'd1;

    if (TMR_W < 1 || TMR_W > 32) begin : g_bad_tmr_w
        $error("hdmi_pll_supervisor: TMR_W must be 1..32");
    end
    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_zero
        $error("hdmi_pll_supervisor: cycle parameters must be at least 1");
    end
    if (64'(RST_CYCLES) > TMR_MAX || 64'(LOCK_TIMEOUT) > TMR_MAX
        || 64'(STABLE_CYCLES) > TMR_MAX) begin : g_bad_tmr
        $error("hdmi_pll_supervisor: a cycle parameter does not fit in TMR_W bits");
    end
    if (MAX_RETRIES < 1 || MAX_RETRIES > RETRY_MAX) begin : g_bad_retries
        $error("hdmi_pll_supervisor: MAX_RETRIES must be 1..15");
    end

    localparam logic [TMR_W-1:0]   RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = RETRY_W'(RETRY_MAX);
    localparam logic [LOSS_W-1:0]  LOSS_SAT     = LOSS_W'(LOCK_LOSS_MAX);

    state_e             state_q;
    logic [TMR_W-1:0]   timer;
    logic [RETRY_W-1:0] retry_inc;
    logic               lk;
    ctl_t               ctl;

    sync_2ff u_lock_sync (
        .clk   (inclk0),
        .rst_n (resetn),
        .d     (locked_async),
        .q     (lk)
    );

    assign retry_inc = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 1'b1;

    // State, timer and counters; control pins are a registered decode of the
    // current state so they never glitch.
    always_ff @(posedge inclk0 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            ctl           <= ctl_decode(ST_IDLE);
        end else begin
            ctl   <= ctl_decode(state_q);
            timer <= '0;
            if (!enable) begin
                state_q <= ST_IDLE;
                if (state_q == ST_FAIL) begin
                    retry_cnt <= '0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_PLL_RST;
                    end
                    ST_PLL_RST: begin
                        if (timer == RST_LAST) begin
                            state_q <= ST_WAIT_LOCK;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // A lock arriving on the timeout cycle wins over the retry.
                        if (lk) begin
                            state_q <= ST_STABLE;
                        end else if (timer == TIMEOUT_LAST) begin
                            retry_cnt <= retry_inc;
                            state_q   <= (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_STABLE: begin
                        if (!lk) begin
                            state_q <= ST_WAIT_LOCK;
                        end else if (timer == STABLE_LAST) begin
                            state_q   <= ST_RUN;
                            retry_cnt <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!lk) begin
                            state_q <= ST_PLL_RST;
                            if (lock_loss_cnt != LOSS_SAT) begin
                                lock_loss_cnt <= lock_loss_cnt + 1'b1;
                            end
                        end
                    end
                    ST_FAIL: begin
                        state_q <= ST_FAIL;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign pll_rst   = ctl.pll_rst;
    assign run_rst_n = ctl.run_rst_n;
    assign fail      = ctl.fail;

endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// Bench for hdmi_pll_supervisor: directed scenarios plus random lock activity,
// every cycle compared against a behavioural model of the supervisor.
module tb_hdmi_pll_supervisor;

    localparam int RST_C = 4;
    localparam int TO    = 20;
    localparam int STB   = 8;
    localparam int MAXR  = 3;

    logic       inclk0;
    logic       resetn;
    logic       enable;
    logic       locked_async;
    logic       pll_rst;
    logic       run_rst_n;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic       fail;

    int n_checks = 0;
    int n_fail   = 0;

    hdmi_pll_supervisor #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (STB),
        .MAX_RETRIES   (MAXR),
        .TMR_W         (16)
    ) dut (
        .inclk0        (inclk0),
        .resetn        (resetn),
        .enable        (enable),
        .locked_async  (locked_async),
        .pll_rst       (pll_rst),
        .run_rst_n     (run_rst_n),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .fail          (fail)
    );

    initial inclk0 = 1'b0;
    always #5 inclk0 = ~inclk0;

    // Reference model: state number, edges spent in the state, counters,
    // two-deep history of the lock pin, and control pins lagging the state.
    int m_st, m_cyc, m_retry, m_loss;
    bit m_s1, m_s2;
    bit m_pll, m_run, m_fail;

    task automatic model_reset();
        m_st = 0; m_cyc = 0; m_retry = 0; m_loss = 0;
        m_s1 = 0; m_s2 = 0;
        m_pll = 1; m_run = 0; m_fail = 0;
    endtask

    task automatic model_edge(input bit en, input bit pin);
        bit lk;
        int ost;
        int nst;
        lk  = m_s2;
        ost = m_st;
        nst = m_st;
        m_s2 = m_s1;
        m_s1 = pin;
        m_pll  = (ost == 0) || (ost == 1) || (ost == 5);
        m_run  = (ost == 4);
        m_fail = (ost == 5);
        if (!en) begin
            if (ost == 5) m_retry = 0;
            nst = 0;
        end else begin
            case (ost)
                0: nst = 1;
                1: if (m_cyc + 1 >= RST_C) nst = 2;
                2: begin
                    if (lk) nst = 3;
                    else if (m_cyc + 1 >= TO) begin
                        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                        nst = (m_retry == MAXR) ? 5 : 1;
                    end
                end
                3: begin
                    if (!lk) nst = 2;
                    else if (m_cyc + 1 >= STB) begin
                        nst = 4;
                        m_retry = 0;
                    end
                end
                4: begin
                    if (!lk) begin
                        nst = 1;
                        if (m_loss < 255) m_loss = m_loss + 1;
                    end
                end
                default: ;
            endcase
        end
        m_cyc = (nst == ost) ? m_cyc + 1 : 0;
        m_st  = nst;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state",         8'(state),         8'(m_st));
        check("retry_cnt",     8'(retry_cnt),     8'(m_retry));
        check("lock_loss_cnt", lock_loss_cnt,     8'(m_loss));
        check("pll_rst",       8'(pll_rst),       8'(m_pll));
        check("run_rst_n",     8'(run_rst_n),     8'(m_run));
        check("fail",          8'(fail),          8'(m_fail));
    endtask

    task automatic step(input bit en, input bit pin);
        enable       = en;
        locked_async = pin;
        @(posedge inclk0);
        model_edge(en, pin);
        #1;
        check_all();
    endtask

    task automatic bring_up();
        repeat (6) step(1'b1, 1'b0);
        repeat (25) step(1'b1, 1'b1);
    endtask

    task automatic async_reset(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"},     8'(state),     8'd0);
        check({tag, "_pll_rst"},   8'(pll_rst),   8'd1);
        check({tag, "_run_rst_n"}, 8'(run_rst_n), 8'd0);
        check({tag, "_retry"},     8'(retry_cnt), 8'd0);
        check({tag, "_loss"},      lock_loss_cnt, 8'd0);
        check({tag, "_fail"},      8'(fail),      8'd0);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        bit pin;
        bit saw_wait;
        bit hit;
        int saved_retry;

        resetn = 1'b0;
        enable = 1'b0;
        locked_async = 1'b0;
        model_reset();
        repeat (2) @(posedge inclk0);
        #1;
        check_all();
        @(negedge inclk0);
        resetn = 1'b1;

        // Clean bring-up
        bring_up();
        check("bringup_state", 8'(state), 8'd4);
        check("bringup_retry", 8'(retry_cnt), 8'd0);
        check("bringup_run_rst_n", 8'(run_rst_n), 8'd1);

        // Lock glitch while qualifying
        step(1'b1, 1'b0);
        repeat (9) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        saw_wait = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            if (state == 3'd2) saw_wait = 1'b1;
        end
        check("glitch_saw_wait", 8'(saw_wait), 8'd1);
        check("glitch_state", 8'(state), 8'd4);
        check("glitch_retry", 8'(retry_cnt), 8'd0);

        // Random lock and enable activity
        pin = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) pin = ~pin;
            step($urandom_range(0, 31) != 0, pin);
        end
        step(1'b0, 1'b0);

        // Lock timeouts until FAIL, then recovery
        repeat (100) step(1'b1, 1'b0);
        check("timeout_state", 8'(state), 8'd5);
        check("timeout_fail", 8'(fail), 8'd1);
        check("timeout_pll_rst", 8'(pll_rst), 8'd1);
        check("timeout_retry", 8'(retry_cnt), 8'(MAXR));
        step(1'b0, 1'b0);
        check("fail_exit_state", 8'(state), 8'd0);
        check("fail_exit_retry", 8'(retry_cnt), 8'd0);
        bring_up();
        check("recover_state", 8'(state), 8'd4);

        // Repeated lock loss until the counter saturates
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0);
            repeat (20) step(1'b1, 1'b1);
        end
        check("loss_saturate", lock_loss_cnt, 8'd255);
        check("loss_run_state", 8'(state), 8'd4);

        // Disable on the exact timeout cycle
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_st == 2 && m_cyc == TO - 1) hit = 1'b1;
            else step(1'b1, 1'b0);
        end
        check("prio_reached_timeout", 8'(hit), 8'd1);
        saved_retry = m_retry;
        step(1'b0, 1'b0);
        check("prio_state", 8'(state), 8'd0);
        check("prio_retry", 8'(retry_cnt), 8'(saved_retry));

        // Asynchronous reset in RUN and in WAIT_LOCK
        bring_up();
        check("pre_reset_run", 8'(state), 8'd4);
        async_reset("arst_run");
        repeat (8) step(1'b1, 1'b0);
        check("pre_reset_wait", 8'(state), 8'd2);
        async_reset("arst_wait");
        repeat (4) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_pll_supervisor.md
Name: hdmi_pll_supervisor

Overview:
Lock supervisor and reset sequencer for the HDMI PLL (48 MHz in; 126 MHz serial, 25.2 MHz pixel out). It runs on the free-running 48 MHz reference and drives the PLL RST pin. It qualifies LOCK over a stable window, releases the HDMI datapath reset only after the lock qualifies, and on lock loss or lock timeout re-resets the PLL and retries. The PLL instance is built with PLLRST_ENA="ENABLED" so that this block can drive RST.

Parameters:
RST_CYCLES, 16, PLL RST pulse width in inclk0 cycles (≥1)
LOCK_TIMEOUT, 48000, max cycles in WAIT_LOCK before a retry (1 ms)
STABLE_CYCLES, 4800, cycles of continuous lock required before RUN (100 µs)
MAX_RETRIES, 7, consecutive lock timeouts before FAIL (1..15)
TMR_W, 16, timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
inclk0  in  1  48 MHz reference clock, sole clock
resetn  in  1  asynchronous active-low reset
enable  in  1  supervisor run request; low forces IDLE
locked_async  in  1  PLL LOCK, asynchronous to inclk0
pll_rst  out  1  to PLL RST, active high
run_rst_n  out  1  HDMI datapath reset, active low
state  out  3  current FSM state code
retry_cnt  out  4  consecutive lock timeouts since last RUN
lock_loss_cnt  out  8  lock losses seen in RUN, saturating
fail  out  1  sticky failure flag

Behaviour:
- Reset (resetn=0, async): state=IDLE, pll_rst=1, run_rst_n=0, retry_cnt=0, lock_loss_cnt=0, fail=0, timer=0, sync FFs=0.
- locked_async passes through a 2-FF synchronizer to give lk. lk lags the pin by 2 edges.
- State codes: IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAIL=5. 6 and 7 are unused and go to IDLE.
- Outputs are Moore decodes of the state register:
  - pll_rst=1 in IDLE, PLL_RST and FAIL.
  - run_rst_n=1 only in RUN.
  - fail=1 only in FAIL.
- The timer clears on every state entry and increments each cycle in a timed state.
- Transitions (enable=0 overrides all and goes to IDLE next edge; counters hold):
  - IDLE: enable=1 → PLL_RST.
  - PLL_RST: after RST_CYCLES cycles in state → WAIT_LOCK.
  - WAIT_LOCK:
    - lk=1 → STABLE.
    - Timer reaches LOCK_TIMEOUT-1 with lk=0 → retry_cnt+1. If the new value equals MAX_RETRIES → FAIL, else → PLL_RST.
  - STABLE:
    - lk=0 → WAIT_LOCK. Timer restarts; no retry increment.
    - STABLE_CYCLES consecutive lk=1 cycles → RUN. retry_cnt clears on entry.
  - RUN:
    - lk=0 → PLL_RST, and lock_loss_cnt+1 (saturates at 255).
    - Latency: locked_async falling before edge N gives run_rst_n=0 after edge N+3.
  - FAIL: sticky. Exit only via enable=0 (→ IDLE) or resetn. On exit to IDLE, retry_cnt clears; lock_loss_cnt is kept.
- Simultaneous events:
  - enable=0 has priority over every transition.
  - In WAIT_LOCK, lk=1 on the timeout cycle goes to STABLE with no retry.
- retry_cnt saturates at 15.
- Timer comparisons are unsigned at TMR_W bits. An elaboration check errors if a cycle parameter exceeds 2^TMR_W-1.
- No output glitches: all outputs come from registers only.

Decomposition:
- Package hdmi_pll_pkg:
  - state enum (3-bit) and its codes
  - default timing constants for 48 MHz: RST/TIMEOUT/STABLE
  - LOCK_LOSS_MAX=255
- Sub-module sync_2ff (1-bit, async active-low reset to 0): the locked synchronizer, reusable for other CDC bits.
- FSM, timer and counters stay in hdmi_pll_supervisor.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
- Clean bring-up: resetn release, enable=1, locked_async rises 2 cycles after pll_rst falls and stays high → pll_rst high exactly 4 cycles in PLL_RST; run_rst_n rises after 8 qualified cycles; state=4, retry_cnt=0.
- Lock glitch in STABLE: locked low for 1 cycle mid-window → state returns to 2 then 3; RUN only 8 full lk cycles after the glitch; retry_cnt stays 0.
- Timeout to fail: locked held 0 → 3 PLL_RST pulses of 4 cycles, each after 20 WAIT_LOCK cycles; after the 3rd timeout state=5, fail=1, pll_rst=1. Pulse enable low for 1 cycle → state=0, retry_cnt=0, bring-up resumes.
- Lock loss in RUN: drop locked at cycle N → run_rst_n=0 at N+3, lock_loss_cnt=1, pll_rst high 4 cycles, re-lock returns to RUN. Repeat 260 times → lock_loss_cnt saturates at 255.
- Async reset mid-operation: assert resetn in RUN and in WAIT_LOCK between clock edges → outputs take reset values immediately (pll_rst=1, run_rst_n=0, counters 0) with no clock edge.
- Enable priority: deassert enable on the same cycle as the WAIT_LOCK timeout → next state=0, retry_cnt unchanged.
